// File: rtl/makestuff_buffer_fifo_pkt_if.sv
`default_nettype none
// ============================================================================
// Module   : makestuff_buffer_fifo_pkt_if
// Brief    : Producer/consumer handshake bundle for the packet buffer FIFO.
// Revision : 1.0
// ============================================================================
interface makestuff_buffer_fifo_pkt_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [DEPTH:0]   depth_out;
  logic [WIDTH-1:0] iData_in;
  logic             iValid_in;
  logic             iLast_in;
  logic             iAbort_in;
  logic             iReady_out;
  logic             iReadyChunk_out;
  logic [WIDTH-1:0] oData_out;
  logic             oLast_out;
  logic             oValid_out;
  logic             oValidChunk_out;
  logic             oReady_in;

  modport slave (
    output depth_out,
    input  iData_in, iValid_in, iLast_in, iAbort_in,
    output iReady_out, iReadyChunk_out,
    output oData_out, oLast_out, oValid_out, oValidChunk_out,
    input  oReady_in
  );

  modport master (
    input  depth_out,
    output iData_in, iValid_in, iLast_in, iAbort_in,
    input  iReady_out, iReadyChunk_out,
    input  oData_out, oLast_out, oValid_out, oValidChunk_out,
    output oReady_in
  );
endinterface
`default_nettype wire

// File: rtl/makestuff_buffer_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module   : makestuff_buffer_fifo_pkt
// Brief    : Single-clock FWFT FIFO with occupancy count and optional
//            commit/abort packet mode.
// Revision : 1.0
// ============================================================================
module makestuff_buffer_fifo_pkt #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int FI_CHUNKSIZE = 2**DEPTH/4,
  parameter int FO_CHUNKSIZE = 2**DEPTH/4,
  parameter int PACKET_MODE  = 0
)(
  input  wire logic                  clk_in,
  input  wire logic                  reset_in,
  makestuff_buffer_fifo_pkt_if.slave bus
);
  localparam int             c_CAPACITY = 2**DEPTH;
  localparam logic [DEPTH:0] c_CAP      = (DEPTH+1)'(c_CAPACITY);
  localparam logic [DEPTH:0] c_ONE      = (DEPTH+1)'(1);

  logic [WIDTH:0]   r_mem [0:c_CAPACITY-1];
  logic [DEPTH:0]   r_wrPtr, r_cmPtr, r_cmVis, r_rdPtr;
  logic [DEPTH:0]   w_wrPtrNext, w_cmPtrNext, w_rdPtrNext;
  logic [DEPTH:0]   w_depth, w_depthNext, w_committed;
  logic [WIDTH-1:0] r_oData;
  logic             r_oLast, r_oValid, w_oValidNext;
  logic             r_iReady, r_iReadyChunk, r_oValidChunk;
  logic             w_abort, w_wrEn, w_load, w_lastBit;

  assign w_abort   = (PACKET_MODE != 0) && bus.iAbort_in;
  assign w_wrEn    = bus.iValid_in && r_iReady && !w_abort;
  assign w_lastBit = (PACKET_MODE != 0) && bus.iLast_in;

  // The read side only sees the commit pointer one cycle late, which gives
  // the two-edge commit-to-valid latency and keeps RAM reads off fresh writes.
  assign w_load       = (r_cmVis != r_rdPtr) && (!r_oValid || bus.oReady_in);
  assign w_rdPtrNext  = r_rdPtr + {{DEPTH{1'b0}}, w_load};
  assign w_oValidNext = w_load || (r_oValid && !bus.oReady_in);

  assign w_depth     = (r_wrPtr - r_rdPtr) + {{DEPTH{1'b0}}, r_oValid};
  assign w_depthNext = (w_wrPtrNext - w_rdPtrNext) + {{DEPTH{1'b0}}, w_oValidNext};
  assign w_committed = (r_cmPtr - r_rdPtr) + {{DEPTH{1'b0}}, r_oValid};

  generate
    if (PACKET_MODE != 0) begin : g_packet
      always_comb begin
        w_wrPtrNext = r_wrPtr;
        w_cmPtrNext = r_cmPtr;
        if (w_abort) begin
          w_wrPtrNext = r_cmPtr;
        end else if (w_wrEn) begin
          w_wrPtrNext = r_wrPtr + c_ONE;
          if (bus.iLast_in) begin
            w_cmPtrNext = r_wrPtr + c_ONE;
          end
        end
      end
    end else begin : g_stream
      assign w_wrPtrNext = r_wrPtr + {{DEPTH{1'b0}}, w_wrEn};
      assign w_cmPtrNext = w_wrPtrNext;
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr[DEPTH-1:0]] <= {w_lastBit, bus.iData_in};
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_wrPtr       <= '0;
      r_cmPtr       <= '0;
      r_cmVis       <= '0;
      r_rdPtr       <= '0;
      r_oValid      <= 1'b0;
      r_oData       <= '0;
      r_oLast       <= 1'b0;
      r_iReady      <= 1'b0;
      r_iReadyChunk <= 1'b0;
      r_oValidChunk <= 1'b0;
    end else begin
      r_wrPtr       <= w_wrPtrNext;
      r_cmPtr       <= w_cmPtrNext;
      r_cmVis       <= r_cmPtr;
      r_rdPtr       <= w_rdPtrNext;
      r_oValid      <= w_oValidNext;
      if (w_load) begin
        {r_oLast, r_oData} <= r_mem[r_rdPtr[DEPTH-1:0]];
      end
      r_iReady      <= (w_depthNext < c_CAP);
      r_iReadyChunk <= (c_CAPACITY - int'(w_depth)) >= FI_CHUNKSIZE;
      r_oValidChunk <= int'(w_committed) >= FO_CHUNKSIZE;
    end
  end

  assign bus.depth_out       = w_depth;
  assign bus.iReady_out      = r_iReady;
  assign bus.iReadyChunk_out = r_iReadyChunk;
  assign bus.oData_out       = r_oData;
  assign bus.oLast_out       = (PACKET_MODE != 0) ? r_oLast : 1'b0;
  assign bus.oValid_out      = r_oValid;
  assign bus.oValidChunk_out = r_oValidChunk;

endmodule
`default_nettype wire

// File: tb/tb_makestuff_buffer_fifo_pkt.sv
`default_nettype none
// ============================================================================
// Module   : tb_makestuff_buffer_fifo_pkt
// Brief    : Stream-mode and packet-mode instances driven by shared stimulus,
//            each checked against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_makestuff_buffer_fifo_pkt;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CAP   = 16;
  localparam int CHUNK = 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             last;
    int               cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] sData;
  logic sValid, sLast, sAbort, sReady;

  makestuff_buffer_fifo_pkt_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  makestuff_buffer_fifo_pkt_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  assign bus0.iData_in  = sData;  assign bus1.iData_in  = sData;
  assign bus0.iValid_in = sValid; assign bus1.iValid_in = sValid;
  assign bus0.iLast_in  = sLast;  assign bus1.iLast_in  = sLast;
  assign bus0.iAbort_in = sAbort; assign bus1.iAbort_in = sAbort;
  assign bus0.oReady_in = sReady; assign bus1.oReady_in = sReady;

  makestuff_buffer_fifo_pkt #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PACKET_MODE(0)) dut0 (
    .clk_in(clk), .reset_in(rst), .bus(bus0));
  makestuff_buffer_fifo_pkt #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PACKET_MODE(1)) dut1 (
    .clk_in(clk), .reset_in(rst), .bus(bus1));

  // Reference: committed beats (with commit edge) and uncommitted packet beats.
  beat_t com0[$];
  beat_t com1[$];
  beat_t pend1[$];
  int    cyc = 0;
  bit    rstPend;
  int    prevDepth[2];
  int    prevCom[2];
  int    tests = 0;
  int    fails = 0;

  function automatic int mDepth(input int k);
    return (k == 0) ? com0.size() : com1.size() + pend1.size();
  endfunction

  function automatic int mCom(input int k);
    return (k == 0) ? com0.size() : com1.size();
  endfunction

  // A beat committed at edge N is presented after edge N+2.
  function automatic bit mValid(input int k);
    if (k == 0) return com0.size() > 0 && com0[0].cyc <= cyc - 2;
    return com1.size() > 0 && com1[0].cyc <= cyc - 2;
  endfunction

  function automatic bit mRdy(input int k);
    return !rstPend && mDepth(k) < CAP;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelClear();
    com0.delete();
    com1.delete();
    pend1.delete();
    rstPend = 1'b1;
    prevDepth = '{-1, -1};
    prevCom   = '{-1, -1};
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      logic [DEPTH:0]   dep;
      logic [WIDTH-1:0] od;
      logic             rdy, irc, ov, ol, ovc;
      beat_t            h;
      int               md, mc;
      if (k == 0) begin
        dep = bus0.depth_out; rdy = bus0.iReady_out; irc = bus0.iReadyChunk_out;
        od = bus0.oData_out; ol = bus0.oLast_out; ov = bus0.oValid_out; ovc = bus0.oValidChunk_out;
      end else begin
        dep = bus1.depth_out; rdy = bus1.iReady_out; irc = bus1.iReadyChunk_out;
        od = bus1.oData_out; ol = bus1.oLast_out; ov = bus1.oValid_out; ovc = bus1.oValidChunk_out;
      end
      md = mDepth(k);
      mc = mCom(k);
      chk($sformatf("depth_m%0d", k), 64'(dep), 64'(md));
      chk($sformatf("iReady_m%0d", k), 64'(rdy), 64'(mRdy(k)));
      chk($sformatf("oValid_m%0d", k), 64'(ov), 64'(mValid(k)));
      if (mValid(k)) begin
        if (k == 0) h = com0[0]; else h = com1[0];
        chk($sformatf("oData_m%0d", k), 64'(od), 64'(h.d));
        chk($sformatf("oLast_m%0d", k), 64'(ol), 64'(h.last));
      end
      // Chunk flags may lag a cycle, so they are only judged when counts were steady.
      if (!rst && prevDepth[k] == md && prevCom[k] == mc) begin
        chk($sformatf("iReadyChunk_m%0d", k), 64'(irc), 64'((CAP - md) >= CHUNK));
        chk($sformatf("oValidChunk_m%0d", k), 64'(ovc), 64'(mc >= CHUNK));
      end
      prevDepth[k] = md;
      prevCom[k]   = mc;
    end
  endtask

  task automatic tick();
    bit    rd0, rd1, wr0, wr1;
    beat_t b, p;
    rd0 = mValid(0) && sReady;
    rd1 = mValid(1) && sReady;
    wr0 = sValid && mRdy(0);
    wr1 = sValid && mRdy(1) && !sAbort;
    @(posedge clk);
    cyc++;
    if (rst) begin
      modelClear();
    end else begin
      rstPend = 1'b0;
      if (rd0) void'(com0.pop_front());
      if (rd1) void'(com1.pop_front());
      b.d = sData; b.cyc = cyc; b.last = 1'b0;
      if (wr0) com0.push_back(b);
      if (sAbort) begin
        pend1.delete();
      end else if (wr1) begin
        b.last = sLast;
        if (sLast) begin
          while (pend1.size() > 0) begin
            p = pend1.pop_front();
            p.cyc = cyc;
            com1.push_back(p);
          end
          com1.push_back(b);
        end else begin
          pend1.push_back(b);
        end
      end
    end
    @(negedge clk);
    checkAll();
  endtask

  task automatic setIn(input logic v, input logic [WIDTH-1:0] d, input logic l,
                       input logic a, input logic r);
    sValid = v; sData = d; sLast = l; sAbort = a; sReady = r;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    setIn(0, '0, 0, 0, 0);
    rst = 1'b1;
    modelClear();
    ticks(3);
    @(negedge clk);
    rst = 1'b0;
    ticks(2);

    // Fill stream instance to capacity; packet instance holds 16 uncommitted.
    for (int i = 0; i < 16; i++) begin
      setIn(1, WIDTH'(i), 0, 0, 0);
      tick();
    end
    setIn(1, 32'hDEAD, 0, 0, 0);
    ticks(3);
    setIn(0, '0, 0, 0, 1);
    ticks(18);
    setIn(0, '0, 0, 1, 1);
    tick();
    setIn(0, '0, 0, 0, 1);
    ticks(3);

    // Single beat latency into empty FIFO.
    setIn(1, 32'hA5, 1, 0, 1);
    tick();
    setIn(0, '0, 0, 0, 1);
    ticks(4);

    // Prime, then steady simultaneous write/read.
    for (int i = 0; i < 4; i++) begin
      setIn(1, 32'h100 + WIDTH'(i), 1, 0, 0);
      tick();
    end
    setIn(0, '0, 0, 0, 0);
    ticks(3);
    for (int i = 0; i < 20; i++) begin
      setIn(1, $urandom, 1, 0, 1);
      tick();
    end
    setIn(0, '0, 0, 0, 1);
    ticks(8);

    // Three-beat packet.
    for (int i = 0; i < 3; i++) begin
      setIn(1, 32'h300 + WIDTH'(i), (i == 2), 0, 1);
      tick();
    end
    setIn(0, '0, 0, 0, 1);
    ticks(6);

    // Five uncommitted beats, then abort coinciding with a last beat.
    for (int i = 0; i < 5; i++) begin
      setIn(1, 32'h500 + WIDTH'(i), 0, 0, 1);
      tick();
    end
    setIn(1, 32'h5FF, 1, 1, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      setIn(1, 32'h600 + WIDTH'(i), (i == 1), 0, 1);
      tick();
    end
    setIn(0, '0, 0, 0, 1);
    ticks(6);

    // Committed packet read out while a second packet is aborted.
    for (int i = 0; i < 4; i++) begin
      setIn(1, 32'h700 + WIDTH'(i), (i == 3), 0, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      setIn(1, 32'h800 + WIDTH'(i), 0, 0, 1);
      tick();
    end
    setIn(0, '0, 0, 1, 1);
    tick();
    setIn(0, '0, 0, 0, 1);
    ticks(6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      setIn($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
      tick();
    end
    setIn(0, '0, 0, 1, 1);
    tick();
    setIn(0, '0, 0, 0, 1);
    ticks(20);

    // Asynchronous reset mid-read with seven entries buffered.
    for (int i = 0; i < 7; i++) begin
      setIn(1, 32'h900 + WIDTH'(i), (i == 6), 0, 0);
      tick();
    end
    setIn(0, '0, 0, 0, 0);
    ticks(3);
    chk("pre_reset_depth_m0", 64'(bus0.depth_out), 64'd7);
    chk("pre_reset_depth_m1", 64'(bus1.depth_out), 64'd7);
    sReady = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("async_oValid_m0", 64'(bus0.oValid_out), 64'd0);
    chk("async_oValid_m1", 64'(bus1.oValid_out), 64'd0);
    chk("async_depth_m0", 64'(bus0.depth_out), 64'd0);
    chk("async_depth_m1", 64'(bus1.depth_out), 64'd0);
    chk("async_iReady_m1", 64'(bus1.iReady_out), 64'd0);
    chk("async_oLast_m1", 64'(bus1.oLast_out), 64'd0);
    chk("async_oValidChunk_m0", 64'(bus0.oValidChunk_out), 64'd0);
    modelClear();
    setIn(0, '0, 0, 0, 0);
    @(negedge clk);
    ticks(2);
    rst = 1'b0;
    ticks(2);
    for (int i = 0; i < 3; i++) begin
      setIn(1, 32'hB00 + WIDTH'(i), (i == 2), 0, 1);
      tick();
    end
    setIn(0, '0, 0, 0, 1);
    ticks(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/makestuff_buffer_fifo_pkt.md
Name: makestuff_buffer_fifo_pkt

Overview:
- Single-clock, self-contained FIFO (own storage, no vendor primitive) for buffering within one clock domain.
- Successor to the basic buffer FIFO: first-word-fall-through registered output, a full-range occupancy count, and optional packet mode.
- In packet mode, writes become visible only on commit (last beat), and an uncommitted packet can be aborted.
- Sits between a producer that may need to discard a partial packet (e.g. failed CRC) and a consumer that must see whole packets only.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 4, log2 of capacity; capacity = 2**DEPTH entries, output stage included.
- FI_CHUNKSIZE, 2**DEPTH/4, free-space threshold for iReadyChunk_out.
- FO_CHUNKSIZE, 2**DEPTH/4, committed-data threshold for oValidChunk_out.
- PACKET_MODE, 0, 0 = every accepted beat committed immediately; 1 = commit on iLast_in, iAbort_in honoured.

Ports:
- clk_in  in  1  clock, rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- depth_out  out  DEPTH+1  entries accepted and not yet consumed, uncommitted included; range 0..2**DEPTH.
- iData_in  in  WIDTH  write data.
- iValid_in  in  1  write request.
- iLast_in  in  1  last beat of packet; ignored when PACKET_MODE=0.
- iAbort_in  in  1  discard uncommitted beats; ignored when PACKET_MODE=0.
- iReady_out  out  1  space for one beat.
- iReadyChunk_out  out  1  free space >= FI_CHUNKSIZE.
- oData_out  out  WIDTH  head data, valid when oValid_out=1.
- oLast_out  out  1  head beat is a packet end; constant 0 when PACKET_MODE=0.
- oValid_out  out  1  committed head beat present.
- oValidChunk_out  out  1  committed unread entries >= FO_CHUNKSIZE.
- oReady_in  in  1  consumer accepts head.

Behaviour:
- Reset (async assert, sync-safe release):
  - depth_out=0, oValid_out=0, oValidChunk_out=0, oLast_out=0.
  - iReady_out=0 while reset_in=1; first edge after release iReady_out=1, iReadyChunk_out=1 (FI_CHUNKSIZE <= 2**DEPTH).
  - All pointers cleared. oData_out is don't-care.
- Write: accepted on an edge with iValid_in && iReady_out. iReady_out = (depth_out < 2**DEPTH), registered/derived from registered state, with no combinational path from iValid_in.
- Read: beat leaves on an edge with oValid_out && oReady_in. oData_out/oLast_out hold stable while oValid_out && !oReady_in.
- Latency: a beat committed at edge N into an empty FIFO gives oValid_out=1 after edge N+2. Back-to-back reads sustain 1 beat/cycle with no bubbles while committed data remains.
- depth_out: +1 per accepted write, -1 per read, net 0 on simultaneous write and read, and -k on abort (k = uncommitted beats discarded). Updated on the same edge.
- Full: depth_out=2**DEPTH gives iReady_out=0. A simultaneous read at full does NOT allow a same-cycle write; iReady_out reasserts the cycle after.
- Empty: oValid_out=0. A write at empty is not bypassed in the same cycle; the latency above applies.
- Pointers: DEPTH+1 bits, wrap naturally modulo 2**(DEPTH+1).
- Chunk flags: recomputed from registered counts and registered themselves (1-cycle lag allowed).
  - iReadyChunk_out = (2**DEPTH - depth_out) >= FI_CHUNKSIZE.
  - oValidChunk_out = committed-unread >= FO_CHUNKSIZE.
- PACKET_MODE=1:
  - Commit pointer advances to the write pointer +1 on an accepted write with iLast_in=1. Only committed beats are visible to the read side.
  - iAbort_in=1 at an edge rewinds the write pointer to the commit pointer.
  - Abort has priority: a write in the same cycle is dropped even if iLast_in=1.
  - Abort with no uncommitted data is a no-op.
  - Abort never affects committed data or a read in the same cycle.
  - oLast_out travels with its beat (stored as an extra storage bit).
  - A packet longer than 2**DEPTH stalls with iReady_out=0 until aborted. This is the producer's responsibility; no internal recovery.
- PACKET_MODE=0: iLast_in and iAbort_in are ignored; commit pointer equals write pointer.
- Reset mid-packet or mid-read: everything discarded, returns to reset state immediately.

Test Plan:
- Mode 0, DEPTH=4: write 16 beats 0..15 with oReady_in=0 -> iReady_out=0 after the 16th, depth_out=16, iReadyChunk_out=0; then oReady_in=1 -> reads 0..15 in order, one per cycle, depth_out back to 0, oValid_out=0.
- Mode 0: single write of 0xA5 into empty FIFO at edge N -> oValid_out=1 after edge N+2, oData_out=0xA5; simultaneous write/read at steady state keeps depth_out constant.
- Mode 1: write 3 beats (last on the 3rd) -> oValid_out stays 0 until the commit edge, then oLast_out=1 on the 3rd read only.
- Mode 1: write 5 uncommitted beats, pulse iAbort_in alongside a 6th beat with iLast_in=1 -> depth_out drops by 5, no output, next committed packet reads correctly.
- Mode 1: committed packet being read while a second packet is aborted -> the first packet is read intact, depth_out is correct each cycle.
- Assert reset_in asynchronously mid-read with depth_out=7 -> all outputs go to reset values without a clock edge, and a subsequent write/read sequence works from empty.
